bht_update_queue: RTL and testbench
===================================

// Module: bht_update_queue
//
// PURPOSE
//  Producer side of the BHT update interface. Accepts resolved conditional branches from EX and
//  flags mispredictions. Maintains the non-speculative global history register (GHR) and
//  buffers update records in a FIFO. Drains one record per cycle into the BHT update port with
//  a valid/ready handshake. Sits between the EX-stage branch unit and the bht module.
//
// PARAMETERS
//  DEPTH    4    FIFO entries; power of 2, >= 2
//  G_DEPTH  4    GHR width in bits; 2 <= G_DEPTH <= IDX_W
//  IDX_W    7    BHT index width (log2 of BHT entries, 128)
//
// PORTS
//  clk            in   1      clock; all state changes on rising edge
//  reset_n        in   1      synchronous reset, active low
//  res_valid      in   1      EX presents a resolved conditional branch
//  res_ready      out  1      queue can accept (= !full)
//  res_pc         in   32     branch PC
//  res_taken      in   1      actual outcome
//  res_pred_taken in   1      outcome predicted at fetch
//  upd_en         out  1      update record valid (= !empty)
//  upd_ready      in   1      BHT accepts record this cycle
//  upd_idx        out  IDX_W  BHT index = res_pc[IDX_W+1:2] ^ {zero-ext, GHR snapshot}
//  upd_taken      out  1      outcome used to train the saturating counter
//  ghr            out  G_DEPTH  current committed history; LSB = most recent branch
//  mispredict     out  1      one-cycle pulse per accepted mispredicted branch
//  br_cnt         out  32     accepted branch count, saturating
//  mispred_cnt    out  32     mispredicted branch count, saturating
//
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): FIFO empties, so wr_ptr = rd_ptr = 0 and count = 0.
//    ghr = 0, br_cnt = 0, mispred_cnt = 0, mispredict = 0.
//    Outputs: res_ready = 1, upd_en = 0, upd_idx = 0, upd_taken = 0.
//  - Reset mid-operation discards all queued records; none are presented to the BHT.
//  - Accept: res_valid && res_ready.
//    * The entry stores idx = res_pc[IDX_W+1:2] ^ ghr_q (the GHR value before this branch).
//    * The entry stores taken = res_taken.
//    * ghr_q <= {ghr_q[G_DEPTH-2:0], res_taken}.
//  - Drain: upd_en && upd_ready pops the head entry.
//    * upd_idx and upd_taken are driven combinationally from the head entry.
//    * When empty, upd_idx and upd_taken are held at 0.
//  - Latency: a branch accepted at edge N first appears on upd_en in the cycle after N.
//    There is no combinational bypass from the res_* inputs to the upd_* outputs.
//  - Full (count == DEPTH): res_ready = 0, even if a pop occurs in the same cycle.
//    res_valid is ignored while full; the producer must hold res_valid and res_* stable until
//    the transfer.
//  - Simultaneous push and pop when not full and not empty: count is unchanged and both
//    pointers advance.
//  - Empty with push: count goes to 1. Pop while empty is impossible because upd_en = 0.
//  - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//  - upd_en must remain asserted and the head entry stable until upd_ready is seen.
//  - mispredict is registered: it is 1 in the cycle after accepting a branch with
//    res_taken != res_pred_taken, and 0 otherwise.
//  - On every accept, br_cnt increments. On a mispredicted accept, mispred_cnt increments.
//    Both counters saturate at 32'hFFFF_FFFF and never wrap.
//
// TESTING
//  - Reset, then idle.
//    -> res_ready = 1, upd_en = 0, ghr = 0, br_cnt = 0, mispred_cnt = 0.
//  - Push pc = 0x0000_0104, taken = 1, pred = 1, with ghr = 0 and upd_ready = 1.
//    -> Next cycle upd_en = 1, upd_idx = 7'h41, upd_taken = 1. Then ghr = 4'b0001.
//    -> mispredict stays 0.
//  - Push 4 branches with upd_ready = 0 (DEPTH = 4).
//    -> res_ready = 0, and a 5th res_valid is held off.
//    -> Raise upd_ready: records drain in order, one per cycle, and res_ready returns next cycle.
//  - Push pc = 0x0000_0010, taken = 0, pred = 1, with ghr = 4'b0011.
//    -> upd_idx = 7'h07, upd_taken = 0. Then ghr = 4'b0110.
//    -> mispredict pulses for exactly 1 cycle. mispred_cnt = 1.
//  - Continuous push and pop, every cycle for 16 cycles, with count = 2.
//    -> count stays 2, pointers wrap, output order is preserved, br_cnt += 16.
//  - Preload br_cnt = 32'hFFFF_FFFE (force), then accept 3 branches.
//    -> br_cnt = 32'hFFFF_FFFF.
//    -> Assert reset with 3 entries queued: upd_en = 0 next cycle and no stale record appears.

Source files
------------

// File: rtl/bht_update_queue_if.sv
// Handshake bundle between the EX branch unit, the BHT update queue and the BHT.
// The queue uses the slave view; the producer/consumer environment uses master.
interface bht_update_queue_if #(
  parameter int IDX_W = 7
);
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_pc;
  logic             res_taken;
  logic             res_pred_taken;
  logic             upd_en;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;

  modport slave (
    input  res_valid, res_pc, res_taken, res_pred_taken, upd_ready,
    output res_ready, upd_en, upd_idx, upd_taken
  );

  modport master (
    output res_valid, res_pc, res_taken, res_pred_taken, upd_ready,
    input  res_ready, upd_en, upd_idx, upd_taken
  );
endinterface

// File: rtl/bht_update_queue.sv
// Buffers resolved branches from EX, tracks the committed GHR and misprediction stats,
// and drains one BHT training record per cycle over a valid/ready handshake.
module bht_update_queue #(
  parameter int DEPTH   = 4,
  parameter int G_DEPTH = 4,
  parameter int IDX_W   = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  bht_update_queue_if.slave   bus,
  output logic [G_DEPTH-1:0]  ghr,
  output logic                mispredict,
  output logic [31:0]         br_cnt,
  output logic [31:0]         mispred_cnt
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  C_FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]  C_CNT_ONE  = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1'b1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  logic [IDX_W-1:0]   r_mem_idx   [DEPTH];
  logic               r_mem_taken [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [G_DEPTH-1:0] r_ghr;
  logic               r_mispredict;
  logic [31:0]        r_br_cnt;
  logic [31:0]        r_mispred_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [IDX_W-1:0]   w_ghr_ext;
  logic [IDX_W-1:0]   w_wr_idx;
  logic               w_unused_pc;

  assign w_full      = (r_count == C_FULL);
  assign w_empty     = (r_count == {(PTR_W+1){1'b0}});
  assign w_push      = bus.res_valid && !w_full;
  assign w_pop       = !w_empty && bus.upd_ready;
  assign w_wr_idx    = bus.res_pc[IDX_W+1:2] ^ w_ghr_ext;
  assign w_unused_pc = ^{bus.res_pc[31:IDX_W+2], bus.res_pc[1:0]};

  // Zero-extend the pre-update history to index width for the hash
  always_comb begin
    w_ghr_ext                = {IDX_W{1'b0}};
    w_ghr_ext[G_DEPTH-1:0]   = r_ghr;
  end

  // Handshake flags and head-of-queue record; record fields are forced to 0 when empty
  always_comb begin
    bus.res_ready = !w_full;
    bus.upd_en    = !w_empty;
    if (w_empty) begin
      bus.upd_idx   = {IDX_W{1'b0}};
      bus.upd_taken = 1'b0;
    end else begin
      bus.upd_idx   = r_mem_idx[r_rd_ptr];
      bus.upd_taken = r_mem_taken[r_rd_ptr];
    end
  end

  // Queue storage, pointers, occupancy, history and statistics
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_idx[i]   <= {IDX_W{1'b0}};
        r_mem_taken[i] <= 1'b0;
      end
      r_wr_ptr      <= {PTR_W{1'b0}};
      r_rd_ptr      <= {PTR_W{1'b0}};
      r_count       <= {(PTR_W+1){1'b0}};
      r_ghr         <= {G_DEPTH{1'b0}};
      r_mispredict  <= 1'b0;
      r_br_cnt      <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else begin
      if (w_push) begin
        r_mem_idx[r_wr_ptr]   <= w_wr_idx;
        r_mem_taken[r_wr_ptr] <= bus.res_taken;
        r_wr_ptr              <= r_wr_ptr + C_PTR_ONE;
        r_ghr                 <= {r_ghr[G_DEPTH-2:0], bus.res_taken};
        r_br_cnt              <= sat_inc(r_br_cnt);
        if (bus.res_taken != bus.res_pred_taken) begin
          r_mispred_cnt <= sat_inc(r_mispred_cnt);
        end else begin
          r_mispred_cnt <= r_mispred_cnt;
        end
      end else begin
        r_wr_ptr      <= r_wr_ptr;
        r_ghr         <= r_ghr;
        r_br_cnt      <= r_br_cnt;
        r_mispred_cnt <= r_mispred_cnt;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase

      r_mispredict <= w_push && (bus.res_taken != bus.res_pred_taken);
    end
  end

  assign ghr         = r_ghr;
  assign mispredict  = r_mispredict;
  assign br_cnt      = r_br_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue: reset, single push, full/backpressure,
// mispredict, continuous streaming, counter saturation and mid-traffic reset.
module tb_bht_update_queue;

  logic        clk;
  logic        reset_n;
  logic [3:0]  ghr;
  logic        mispredict;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;
  int          n_tests;
  int          n_fail;

  bht_update_queue_if #(.IDX_W(7)) bus ();

  bht_update_queue #(.DEPTH(4), .G_DEPTH(4), .IDX_W(7)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .ghr         (ghr),
    .mispredict  (mispredict),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic t, input logic p);
    bus.res_valid      = 1'b1;
    bus.res_pc         = pc;
    bus.res_taken      = t;
    bus.res_pred_taken = p;
  endtask

  // Expected index of stream item k: pc = k<<2, GHR history 0110 -> 1100 -> 1000 -> 0000
  function automatic logic [31:0] stream_idx(input int k);
    case (k)
      0:       return 32'h06;
      1:       return 32'h0D;
      2:       return 32'h0A;
      default: return 32'(k);
    endcase
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n            = 1'b0;
    bus.res_valid      = 1'b0;
    bus.res_pc         = 32'd0;
    bus.res_taken      = 1'b0;
    bus.res_pred_taken = 1'b0;
    bus.upd_ready      = 1'b0;
    step();
    step();
    check_eq("rst_res_ready", 32'(bus.res_ready), 32'd1);
    check_eq("rst_upd_en", 32'(bus.upd_en), 32'd0);
    check_eq("rst_upd_idx", 32'(bus.upd_idx), 32'd0);
    check_eq("rst_upd_taken", 32'(bus.upd_taken), 32'd0);
    check_eq("rst_ghr", 32'(ghr), 32'd0);
    check_eq("rst_br_cnt", br_cnt, 32'd0);
    check_eq("rst_mispred_cnt", mispred_cnt, 32'd0);
    check_eq("rst_mispredict", 32'(mispredict), 32'd0);
    reset_n = 1'b1;
    step();
    check_eq("idle_upd_en", 32'(bus.upd_en), 32'd0);

    // Single push
    bus.upd_ready = 1'b1;
    drive(32'h0000_0104, 1'b1, 1'b1);
    step();
    bus.res_valid = 1'b0;
    check_eq("p1_upd_en", 32'(bus.upd_en), 32'd1);
    check_eq("p1_upd_idx", 32'(bus.upd_idx), 32'h41);
    check_eq("p1_upd_taken", 32'(bus.upd_taken), 32'd1);
    check_eq("p1_ghr", 32'(ghr), 32'h1);
    check_eq("p1_mispredict", 32'(mispredict), 32'd0);
    check_eq("p1_br_cnt", br_cnt, 32'd1);
    step();
    check_eq("p1_drained", 32'(bus.upd_en), 32'd0);

    // Fill to DEPTH with the BHT stalled
    bus.upd_ready = 1'b0;
    drive(32'h20, 1'b1, 1'b1); step();
    drive(32'h24, 1'b0, 1'b0); step();
    drive(32'h28, 1'b1, 1'b1); step();
    drive(32'h2C, 1'b1, 1'b1); step();
    check_eq("full_res_ready", 32'(bus.res_ready), 32'd0);
    check_eq("full_count", 32'(dut.r_count), 32'd4);
    drive(32'h30, 1'b0, 1'b0);
    step();
    step();
    check_eq("hold_res_ready", 32'(bus.res_ready), 32'd0);
    check_eq("hold_br_cnt", br_cnt, 32'd5);
    check_eq("hold_ghr", 32'(ghr), 32'hB);
    check_eq("hold_head_idx", 32'(bus.upd_idx), 32'h09);
    check_eq("hold_head_taken", 32'(bus.upd_taken), 32'd1);
    bus.upd_ready = 1'b1;
    step();
    check_eq("drain_res_ready", 32'(bus.res_ready), 32'd1);
    check_eq("drain_b_idx", 32'(bus.upd_idx), 32'h0A);
    check_eq("drain_b_taken", 32'(bus.upd_taken), 32'd0);
    step();
    bus.res_valid = 1'b0;
    check_eq("drain_c_idx", 32'(bus.upd_idx), 32'h0C);
    check_eq("drain_c_taken", 32'(bus.upd_taken), 32'd1);
    step();
    check_eq("drain_d_idx", 32'(bus.upd_idx), 32'h06);
    step();
    check_eq("drain_e_idx", 32'(bus.upd_idx), 32'h07);
    check_eq("drain_e_taken", 32'(bus.upd_taken), 32'd0);
    step();
    check_eq("drain_empty", 32'(bus.upd_en), 32'd0);
    check_eq("drain_ghr", 32'(ghr), 32'h6);
    check_eq("drain_br_cnt", br_cnt, 32'd6);

    // Bring history to 0011 then push a mispredicted branch
    drive(32'h40, 1'b0, 1'b0); step();
    drive(32'h44, 1'b0, 1'b0); step();
    drive(32'h48, 1'b1, 1'b1); step();
    drive(32'h4C, 1'b1, 1'b1); step();
    check_eq("pre_mp_ghr", 32'(ghr), 32'h3);
    check_eq("pre_mp_mispredict", 32'(mispredict), 32'd0);
    drive(32'h10, 1'b0, 1'b1);
    step();
    bus.res_valid = 1'b0;
    check_eq("mp_upd_idx", 32'(bus.upd_idx), 32'h07);
    check_eq("mp_upd_taken", 32'(bus.upd_taken), 32'd0);
    check_eq("mp_ghr", 32'(ghr), 32'h6);
    check_eq("mp_pulse", 32'(mispredict), 32'd1);
    check_eq("mp_cnt", mispred_cnt, 32'd1);
    step();
    check_eq("mp_pulse_end", 32'(mispredict), 32'd0);
    check_eq("mp_drained", 32'(bus.upd_en), 32'd0);
    check_eq("mp_br_cnt", br_cnt, 32'd11);

    // Steady stream with two records in flight
    bus.upd_ready = 1'b0;
    drive(32'h0, 1'b0, 1'b0); step();
    drive(32'h4, 1'b0, 1'b0); step();
    bus.upd_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check_eq("stream_head_pre", 32'(bus.upd_idx), stream_idx(j));
      drive(32'(j + 2) << 2, 1'b0, 1'b0);
      step();
      check_eq("stream_count", 32'(dut.r_count), 32'd2);
    end
    check_eq("stream_head_last", 32'(bus.upd_idx), stream_idx(16));
    bus.res_valid = 1'b0;
    check_eq("stream_br_cnt", br_cnt, 32'd29);
    step();
    step();
    check_eq("stream_drained", 32'(bus.upd_en), 32'd0);

    // Counter saturation, then reset with records queued
    bus.upd_ready = 1'b0;
    force dut.r_br_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_br_cnt;
    drive(32'h50, 1'b1, 1'b1); step();
    check_eq("sat_1", br_cnt, 32'hFFFF_FFFF);
    drive(32'h54, 1'b1, 1'b1); step();
    check_eq("sat_2", br_cnt, 32'hFFFF_FFFF);
    drive(32'h58, 1'b1, 1'b1); step();
    bus.res_valid = 1'b0;
    check_eq("sat_3", br_cnt, 32'hFFFF_FFFF);
    check_eq("sat_queued", 32'(dut.r_count), 32'd3);
    check_eq("sat_upd_en", 32'(bus.upd_en), 32'd1);
    reset_n = 1'b0;
    step();
    check_eq("mid_rst_upd_en", 32'(bus.upd_en), 32'd0);
    check_eq("mid_rst_res_ready", 32'(bus.res_ready), 32'd1);
    check_eq("mid_rst_upd_idx", 32'(bus.upd_idx), 32'd0);
    check_eq("mid_rst_br_cnt", br_cnt, 32'd0);
    check_eq("mid_rst_ghr", 32'(ghr), 32'd0);
    reset_n = 1'b1;
    bus.upd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("post_rst_no_stale", 32'(bus.upd_en), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
